// File: rtl/syn_pkg.sv
// Shared types and constants for the synaptic weight RMW controller.
package syn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    localparam logic OP_READ   = 1'b0;
    localparam logic OP_UPDATE = 1'b1;

    localparam int unsigned SYN_W_BITS = 4;

endpackage

// File: rtl/syn_word_update.sv
// Combinational saturating +/-1 on each masked packed weight of a word.
module syn_word_update
    import syn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned W_BITS     = SYN_W_BITS,
    localparam int unsigned NSYN      = DATA_WIDTH / W_BITS
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [NSYN-1:0]       mask,
    input  logic [NSYN-1:0]       sign,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [W_BITS-1:0] W_MAX = '1;

    logic [W_BITS-1:0] fld;

    // Each field saturates on its own; no carry between neighbours.
    always_comb begin
        result = word;
        fld    = '0;
        for (int i = 0; i < int'(NSYN); i++) begin
            fld = word[i*W_BITS +: W_BITS];
            if (mask[i]) begin
                if (sign[i]) begin
                    if (fld != '0) begin
                        result[i*W_BITS +: W_BITS] = fld - W_BITS'(1);
                    end
                end else if (fld != W_MAX) begin
                    result[i*W_BITS +: W_BITS] = fld + W_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/synaptic_rmw_ctrl.sv
// Read-modify-write controller owning the synaptic weight SRAM port.
// Optional macro SYN_UPD_CNT_EN adds the UPD_CNT completed-update counter.
module synaptic_rmw_ctrl
    import syn_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned W_BITS     = SYN_W_BITS,
    localparam int unsigned NSYN      = DATA_WIDTH / W_BITS
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_OP,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NSYN-1:0]       REQ_MASK,
    input  logic [NSYN-1:0]       REQ_SIGN,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  SRAM_CS,
    output logic                  SRAM_WE,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
`ifdef SYN_UPD_CNT_EN
    ,
    output logic [15:0]           UPD_CNT
`endif
);

    state_t                state, state_next;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NSYN-1:0]       mask_q, mask_d;
    logic [NSYN-1:0]       sign_q, sign_d;

    logic                  ready_d, rsp_valid_d, cs_d, we_d;
    logic [DATA_WIDTH-1:0] rsp_data_d, sram_d_d;
    logic [ADDR_WIDTH-1:0] sram_a_d;
    logic [DATA_WIDTH-1:0] new_word;

    syn_word_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .W_BITS     (W_BITS)
    ) u_word_update (
        .word   (SRAM_Q),
        .mask   (mask_q),
        .sign   (sign_q),
        .result (new_word)
    );

    // Outputs are computed for the state being entered, so they are
    // valid exactly while the FSM sits in that state.
    always_comb begin
        state_next  = state;
        op_d        = op_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        sign_d      = sign_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = RSP_DATA;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        sram_a_d    = '0;
        sram_d_d    = '0;
        unique case (state)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    op_d       = REQ_OP;
                    addr_d     = REQ_ADDR;
                    mask_d     = REQ_MASK;
                    sign_d     = REQ_SIGN;
                    cs_d       = 1'b1;
                    sram_a_d   = REQ_ADDR;
                    state_next = ST_RD;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_RD: begin
                state_next = ST_CAP;
            end
            ST_CAP: begin
                if (op_q == OP_UPDATE) begin
                    cs_d       = 1'b1;
                    we_d       = 1'b1;
                    sram_a_d   = addr_q;
                    sram_d_d   = new_word;
                    state_next = ST_WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = SRAM_Q;
                    ready_d     = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_WR: begin
                ready_d    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            op_q      <= 1'b0;
            addr_q    <= '0;
            mask_q    <= '0;
            sign_q    <= '0;
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            SRAM_CS   <= 1'b0;
            SRAM_WE   <= 1'b0;
            SRAM_A    <= '0;
            SRAM_D    <= '0;
        end else begin
            state     <= state_next;
            op_q      <= op_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            sign_q    <= sign_d;
            REQ_READY <= ready_d;
            RSP_VALID <= rsp_valid_d;
            RSP_DATA  <= rsp_data_d;
            SRAM_CS   <= cs_d;
            SRAM_WE   <= we_d;
            SRAM_A    <= sram_a_d;
            SRAM_D    <= sram_d_d;
        end
    end

`ifdef SYN_UPD_CNT_EN
    // Counts write-back edges; wraps naturally at 16 bits.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            UPD_CNT <= '0;
        end else if (state == ST_WR) begin
            UPD_CNT <= UPD_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_synaptic_rmw_ctrl.sv
// Scoreboard bench for synaptic_rmw_ctrl with a behavioural SRAM model.
module tb_synaptic_rmw_ctrl;
    import syn_pkg::*;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_OP = 1'b0;
    logic [7:0]  REQ_ADDR = '0;
    logic [7:0]  REQ_MASK = '0;
    logic [7:0]  REQ_SIGN = '0;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic        SRAM_CS, SRAM_WE;
    logic [7:0]  SRAM_A;
    logic [31:0] SRAM_D;
    logic [31:0] SRAM_Q = '0;
`ifdef SYN_UPD_CNT_EN
    logic [15:0] UPD_CNT;
`endif

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    logic [31:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          upd_model = 0;

    synaptic_rmw_ctrl dut (
        .CK        (CK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_OP    (REQ_OP),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_MASK  (REQ_MASK),
        .REQ_SIGN  (REQ_SIGN),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .SRAM_CS   (SRAM_CS),
        .SRAM_WE   (SRAM_WE),
        .SRAM_A    (SRAM_A),
        .SRAM_D    (SRAM_D),
        .SRAM_Q    (SRAM_Q)
`ifdef SYN_UPD_CNT_EN
        ,
        .UPD_CNT   (UPD_CNT)
`endif
    );

    always #5 CK = ~CK;

    // Single-port synchronous SRAM with a one-cycle registered read and a backdoor loader.
    always @(posedge CK) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (SRAM_CS) begin
            if (SRAM_WE) mem[SRAM_A] <= SRAM_D;
            else         SRAM_Q <= mem[SRAM_A];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_upd(input logic [31:0] w, input logic [7:0] m,
                                              input logic [7:0] s);
        logic [31:0] r;
        int f;
        r = w;
        for (int i = 0; i < 8; i++) begin
            f = int'((w >> (4 * i)) & 32'hF);
            if (m[i]) begin
                if (s[i]) f = (f > 0) ? f - 1 : 0;
                else      f = (f < 15) ? f + 1 : 15;
            end
            r[4*i +: 4] = 4'(f);
        end
        return r;
    endfunction

    // Read responses are popped from the scoreboard as they appear.
    always @(negedge CK) begin
        if (RSP_VALID) begin
            if (exp_q.size() == 0) check_eq("rsp_extra", 32'(exp_q.size()), 32'd1);
            else                   check_eq("rsp_data", RSP_DATA, exp_q.pop_front());
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge CK);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge CK);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic do_op(input logic op, input logic [7:0] addr, input logic [7:0] mask,
                         input logic [7:0] sign);
        int waitc, ready_cyc, rsp_cyc, we_cyc, we_cnt;
        logic [31:0] exp_wr, d_at_we;
        waitc = 0;
        while (!REQ_READY && waitc < 20) begin
            @(negedge CK);
            waitc++;
        end
        check_eq("ready_wait", 32'(REQ_READY), 32'd1);
        REQ_VALID = 1'b1; REQ_OP = op; REQ_ADDR = addr; REQ_MASK = mask; REQ_SIGN = sign;
        exp_wr = '0;
        if (op == OP_READ) begin
            exp_q.push_back(ref_mem[addr]);
        end else begin
            exp_wr = model_upd(ref_mem[addr], mask, sign);
            ref_mem[addr] = exp_wr;
            upd_model++;
        end
        @(negedge CK);
        // Garbage on the inputs while busy must be ignored.
        REQ_VALID = 1'b0; REQ_OP = 1'($urandom); REQ_ADDR = 8'($urandom);
        REQ_MASK = 8'($urandom); REQ_SIGN = 8'($urandom);
        ready_cyc = 0; rsp_cyc = 0; we_cyc = 0; we_cnt = 0; d_at_we = '0;
        for (int n = 1; n <= 8; n++) begin
            if (RSP_VALID) rsp_cyc = n;
            if (SRAM_WE) begin
                we_cnt++;
                we_cyc = n;
                d_at_we = SRAM_D;
                check_eq("wr_addr", 32'(SRAM_A), 32'(addr));
            end
            if (n == 1) begin
                check_eq("rd_phase_cs_we", {30'd0, SRAM_CS, SRAM_WE}, 32'd2);
                check_eq("rd_phase_addr", 32'(SRAM_A), 32'(addr));
            end
            if (REQ_READY) begin
                ready_cyc = n;
                break;
            end
            @(negedge CK);
        end
        REQ_OP = 1'b0; REQ_ADDR = '0; REQ_MASK = '0; REQ_SIGN = '0;
        if (op == OP_READ) begin
            check_eq("rd_ready_latency", 32'(ready_cyc), 32'd3);
            check_eq("rd_rsp_cycle", 32'(rsp_cyc), 32'd3);
            check_eq("rd_no_we", 32'(we_cnt), 32'd0);
        end else begin
            check_eq("upd_ready_latency", 32'(ready_cyc), 32'd4);
            check_eq("upd_we_cycle", 32'(we_cyc), 32'd3);
            check_eq("upd_we_count", 32'(we_cnt), 32'd1);
            check_eq("upd_wr_data", d_at_we, exp_wr);
            check_eq("upd_no_rsp", 32'(rsp_cyc), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (2) @(negedge CK);
        for (int i = 0; i < 256; i++) begin
            bd_we = 1'b1; bd_addr = 8'(i); bd_data = '0;
            @(negedge CK);
        end
        bd_we = 1'b0;
        check_eq("rst_ready", 32'(REQ_READY), 32'd1);
        check_eq("rst_outs", {28'd0, RSP_VALID, SRAM_CS, SRAM_WE, 1'b0}, 32'd0);
        check_eq("rst_rsp_data", RSP_DATA, 32'd0);
        check_eq("rst_sram_a_d", {24'd0, SRAM_A} | SRAM_D, 32'd0);
        RST = 1'b0;
        @(negedge CK);

        // Plain read
        preload(8'h05, 32'h1234_5678);
        do_op(OP_READ, 8'h05, 8'h00, 8'h00);

        // Full-mask update mixing potentiate and depress with saturation
        preload(8'h10, 32'h0F00_F0A1);
        do_op(OP_UPDATE, 8'h10, 8'hFF, 8'h0F);
        check_eq("upd_const", mem[8'h10], 32'h1F11_E090);
        do_op(OP_READ, 8'h10, 8'h00, 8'h00);

        // Single-field and empty-mask updates
        preload(8'h20, 32'h7777_7777);
        do_op(OP_UPDATE, 8'h20, 8'h01, 8'h00);
        check_eq("mask1_const", mem[8'h20], 32'h7777_7778);
        do_op(OP_UPDATE, 8'h20, 8'h00, 8'hFF);
        check_eq("mask0_unchanged", mem[8'h20], 32'h7777_7778);
        do_op(OP_READ, 8'h20, 8'h00, 8'h00);

        // Back-to-back update then read of the same address
        do_op(OP_UPDATE, 8'h03, 8'h01, 8'h00);
        do_op(OP_READ, 8'h03, 8'h00, 8'h00);
        check_eq("b2b_mem", mem[8'h03], 32'h0000_0001);

        // Saturation corners and random traffic
        preload(8'h40, 32'hFFFF_FFFF);
        preload(8'h41, 32'h0000_0000);
        preload(8'h42, $urandom);
        preload(8'h43, 32'h8888_8888);
        for (int k = 0; k < 16; k++) begin
            do_op(1'($urandom), 8'h40 + 8'(k % 4), 8'($urandom), 8'($urandom));
        end

        // Reset during CAP of an update must not write
        preload(8'h07, 32'hAAAA_AAAA);
        REQ_VALID = 1'b1; REQ_OP = OP_UPDATE; REQ_ADDR = 8'h07;
        REQ_MASK = 8'hFF; REQ_SIGN = 8'h00;
        @(negedge CK);
        REQ_VALID = 1'b0;
        @(negedge CK);
        RST = 1'b1;
        #1;
        check_eq("midrst_cs_we", {30'd0, SRAM_CS, SRAM_WE}, 32'd0);
        check_eq("midrst_ready", 32'(REQ_READY), 32'd1);
        upd_model = 0;
        repeat (2) @(negedge CK);
        RST = 1'b0;
        @(negedge CK);
        check_eq("midrst_ready_after", 32'(REQ_READY), 32'd1);
        check_eq("midrst_mem", mem[8'h07], 32'hAAAA_AAAA);
        do_op(OP_READ, 8'h07, 8'h00, 8'h00);

        // Counter after a known mix of updates and reads
        for (int k = 0; k < 5; k++) do_op(OP_UPDATE, 8'h50, 8'h01, 8'h00);
        for (int k = 0; k < 3; k++) do_op(OP_READ, 8'h50, 8'h00, 8'h00);
`ifdef SYN_UPD_CNT_EN
        check_eq("upd_cnt", 32'(UPD_CNT), 32'(upd_model));
`endif

        repeat (3) @(negedge CK);
        check_eq("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== ref_mem[a]) check_eq("final_mem", mem[a], ref_mem[a]);
        end
        check_eq("final_mem_50", mem[8'h50], 32'h0000_0005);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
